// File: rtl/dm_slave_pkg.sv
// Shared definitions for the data-memory responder: FSM encodings, default
// wait-state count and the byte-enable lane mapping used by the M stage.
package dm_slave_pkg;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_WAIT = 2'd1,
    DM_RESP = 2'd2
  } dmState;

  localparam int DEF_WAIT_CYC = 2;
  localparam int LANES        = 4;

  // BE[i] selects byte lane bits [8*i+7:8*i].
  function automatic logic [31:0] laneMask(input logic [LANES-1:0] be);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

endpackage

// File: rtl/dm_slave_ram.sv
// Word array with per-lane write enables, registered read port and an
// asynchronous clear of the whole array on reset.
module dm_slave_ram
  import dm_slave_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [LANES-1:0]  wrEn,
  input  logic              rdEn,
  input  logic              rdClr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wData,
  output logic [31:0]       rData
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [31:0] mem [DEPTH];
  logic [31:0] mask;

  assign mask = laneMask(wrEn);

  // NOTE: the array itself is reset here because software relies on it
  // reading back zero after reset; this rules out a RAM macro.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rData <= '0;
    end else begin
      if (|wrEn) mem[addr] <= (mem[addr] & ~mask) | (wData & mask);
      if (rdClr)     rData <= '0;
      else if (rdEn) rData <= mem[addr];
    end
  end

endmodule

// File: rtl/dm_slave.sv
// Multi-cycle data-memory responder: accepts one load/store, stalls the
// pipeline for WAIT_CYC cycles, then pulses Ready with the read data.
module dm_slave
  import dm_slave_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int WAIT_CYC = DEF_WAIT_CYC
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        We,
  input  logic [31:0] Addr,
  input  logic [3:0]  BE,
  input  logic [31:0] WData,
  output logic [31:0] RData,
  output logic        Ready,
  output logic        Busy,
  output logic        AddrErr
);

  dmState state, nextState;
  logic [3:0]        cnt;
  logic              accept, commit;
  logic              reqWe, reqErr;
  logic [ADDR_W-1:0] reqAddr;
  logic [3:0]        reqBe;
  logic [31:0]       reqWData;

  logic              inErr, curWe, curErr;
  logic [ADDR_W-1:0] curAddr;
  logic [3:0]        curBe;
  logic [31:0]       curWData;
  logic              unusedAddrBits;

  assign unusedAddrBits = &{1'b0, Addr[1:0]};
  assign inErr = (Addr[31:ADDR_W+2] != '0);

  // With zero wait states the commit happens on the accept edge, so the
  // live inputs are used instead of the (not yet loaded) latches.
  assign curWe    = accept ? We                 : reqWe;
  assign curErr   = accept ? inErr              : reqErr;
  assign curAddr  = accept ? Addr[ADDR_W+1:2]   : reqAddr;
  assign curBe    = accept ? BE                 : reqBe;
  assign curWData = accept ? WData              : reqWData;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= DM_IDLE;
    else        state <= nextState;
  end

  // NOTE: every output of this block gets a default first so no latch is
  // inferred on paths the case statement does not mention.
  always_comb begin
    nextState = state;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      DM_IDLE: if (Req) begin
        accept = 1'b1;
        if (WAIT_CYC == 0) begin
          commit    = 1'b1;
          nextState = DM_RESP;
        end else begin
          nextState = DM_WAIT;
        end
      end
      DM_WAIT: if (cnt == 4'd1) begin
        commit    = 1'b1;
        nextState = DM_RESP;
      end
      DM_RESP: nextState = DM_IDLE;
      default: nextState = DM_IDLE;
    endcase
  end

  assign Ready = (state == DM_RESP);
  assign Busy  = Reset & (((state == DM_IDLE) & Req) | (state == DM_WAIT));

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt      <= '0;
      reqWe    <= 1'b0;
      reqErr   <= 1'b0;
      reqAddr  <= '0;
      reqBe    <= '0;
      reqWData <= '0;
      AddrErr  <= 1'b0;
    end else begin
      if (accept) begin
        cnt      <= 4'(WAIT_CYC);
        reqWe    <= We;
        reqErr   <= inErr;
        reqAddr  <= Addr[ADDR_W+1:2];
        reqBe    <= BE;
        reqWData <= WData;
      end else if (state == DM_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (commit)      AddrErr <= curErr;
      else if (accept) AddrErr <= 1'b0;
    end
  end

  dm_slave_ram #(.ADDR_W(ADDR_W)) uRam (
    .Clk   (Clk),
    .Reset (Reset),
    .wrEn  ({4{commit & curWe & ~curErr}} & curBe),
    .rdEn  (commit & ~curWe & ~curErr),
    .rdClr (commit & curErr),
    .addr  (curAddr),
    .wData (curWData),
    .rData (RData)
  );

endmodule

// File: tb/tb_dm_slave.sv
// Directed bench: one responder with two wait states, one with none,
// sharing clock and reset.
module tb_dm_slave;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic        req2 = 0, we2 = 0;
  logic [31:0] addr2 = 0, wData2 = 0;
  logic [3:0]  be2 = 0;
  logic [31:0] rData2;
  logic        ready2, busy2, addrErr2;

  logic        req0 = 0, we0 = 0;
  logic [31:0] addr0 = 0, wData0 = 0;
  logic [3:0]  be0 = 0;
  logic [31:0] rData0;
  logic        ready0, busy0, addrErr0;

  always #5 Clk = ~Clk;

  dm_slave #(.ADDR_W(12), .WAIT_CYC(2)) dut2 (
    .Clk(Clk), .Reset(Reset), .Req(req2), .We(we2), .Addr(addr2), .BE(be2),
    .WData(wData2), .RData(rData2), .Ready(ready2), .Busy(busy2), .AddrErr(addrErr2)
  );

  dm_slave #(.ADDR_W(12), .WAIT_CYC(0)) dut0 (
    .Clk(Clk), .Reset(Reset), .Req(req0), .We(we0), .Addr(addr0), .BE(be0),
    .WData(wData0), .RData(rData0), .Ready(ready0), .Busy(busy0), .AddrErr(addrErr0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One access on the two-wait-state instance: Busy in cycles 0..2,
  // Ready in cycle 3 with the response.
  task automatic access2(input string tag, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wdata,
                         input logic [31:0] expR, input logic expErr);
    @(negedge Clk);
    req2 = 1'b1; we2 = we; addr2 = addr; be2 = be; wData2 = wdata;
    #1;
    check({tag, " busy c0"}, 32'(busy2), 32'd1);
    check({tag, " ready c0"}, 32'(ready2), 32'd0);
    for (int c = 1; c <= 2; c++) begin
      @(negedge Clk);
      we2 = ~we; addr2 = 32'hFFFF_FFFC; wData2 = 32'h0BAD_0BAD;
      check({tag, " busy wait"}, 32'(busy2), 32'd1);
      check({tag, " ready wait"}, 32'(ready2), 32'd0);
    end
    @(negedge Clk);
    check({tag, " ready c3"}, 32'(ready2), 32'd1);
    check({tag, " busy c3"}, 32'(busy2), 32'd0);
    check({tag, " addrErr"}, 32'(addrErr2), 32'(expErr));
    if (!we) check({tag, " rdata"}, rData2, expR);
    req2 = 1'b0;
  endtask

  initial begin
    #1;
    check("rst busy2", 32'(busy2), 32'd0);
    check("rst ready2", 32'(ready2), 32'd0);
    check("rst rdata2", rData2, 32'd0);
    check("rst addrErr2", 32'(addrErr2), 32'd0);
    check("rst ready0", 32'(ready0), 32'd0);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;

    access2("st10", 1'b1, 32'h10, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0);
    access2("ld10", 1'b0, 32'h10, 4'b0000, 32'h0, 32'hDEAD_BEEF, 1'b0);
    access2("pst10", 1'b1, 32'h10, 4'b0101, 32'h1122_3344, 32'h0, 1'b0);
    access2("pld10", 1'b0, 32'h10, 4'b0000, 32'h0, 32'hDE22_BE44, 1'b0);
    @(negedge Clk);
    check("rdata hold", rData2, 32'hDE22_BE44);

    access2("st0", 1'b1, 32'h0, 4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0);
    access2("oorSt", 1'b1, 32'h0001_0000, 4'b1111, 32'h7777_7777, 32'h0, 1'b1);
    access2("oorLd", 1'b0, 32'h0001_0000, 4'b0000, 32'h0, 32'h0, 1'b1);
    access2("ld0", 1'b0, 32'h0, 4'b0000, 32'h0, 32'hCAFE_F00D, 1'b0);

    // Zero wait states, Req held high across three accesses.
    for (int c = 0; c < 6; c++) begin
      @(negedge Clk);
      case (c)
        0: begin req0 = 1; we0 = 0; addr0 = 32'h40; be0 = 4'h0; wData0 = 32'h0; end
        2: begin we0 = 1; be0 = 4'hF; wData0 = 32'h1234_5678; end
        4: begin we0 = 0; be0 = 4'h0; wData0 = 32'h0; end
        default: ;
      endcase
      #1;
      check($sformatf("b2b busy c%0d", c), 32'(busy0), 32'(c % 2 == 0));
      check($sformatf("b2b ready c%0d", c), 32'(ready0), 32'(c % 2 == 1));
      if (c == 1) check("b2b rdata1", rData0, 32'h0);
      if (c == 5) check("b2b rdata5", rData0, 32'h1234_5678);
    end
    req0 = 1'b0;

    // Reset during the wait of a store.
    @(negedge Clk);
    req2 = 1; we2 = 1; addr2 = 32'h20; be2 = 4'hF; wData2 = 32'h5A5A_5A5A;
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    check("midrst ready", 32'(ready2), 32'd0);
    check("midrst busy", 32'(busy2), 32'd0);
    check("midrst rdata", rData2, 32'd0);
    @(negedge Clk);
    req2 = 0;
    @(negedge Clk);
    Reset = 1'b1;
    access2("ld20", 1'b0, 32'h20, 4'b0000, 32'h0, 32'h0, 1'b0);
    access2("ld10clr", 1'b0, 32'h10, 4'b0000, 32'h0, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
